// File: rtl/ne_pkg.sv
// Shared types and default widths for the nonlinear-energy chain.
// Used by ne_comp_unit, ne_window_accum and the detector stage.
package ne_pkg;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_ACCUM  = 1'b1
    } ne_state_e;

    localparam int NE_IN_W  = 32;
    localparam int NE_ACC_W = 48;

endpackage

// File: rtl/ne_window_accum.sv
// Sums the NE sample stream over non-overlapping windows of WIN_LEN valid
// samples after a SKIP-sample warm-up, and flags window sums above thresh.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   din, din_valid     : signed NE sample and its qualifier
//   clear              : restart (drops partial window, re-enters warm-up)
//   thresh             : signed threshold, sampled at window completion
//   dout, dout_valid   : signed window sum and its one-cycle pulse
//   above_thresh       : registered dout > thresh (signed)
module ne_window_accum
    import ne_pkg::*;
#(
    parameter int IN_W    = NE_IN_W,
    parameter int WIN_LEN = 256,
    parameter int SKIP    = 2,
    parameter int ACC_W   = NE_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  din,
    input  logic             din_valid,
    input  logic             clear,
    input  logic [ACC_W-1:0] thresh,
    output logic [ACC_W-1:0] dout,
    output logic             dout_valid,
    output logic             above_thresh
);

    localparam int CNT_W  = $clog2(WIN_LEN);
    localparam int SKIP_W = (SKIP < 2) ? 1 : $clog2(SKIP);

    // With no warm-up, reset and clear land directly in ACCUM.
    localparam ne_state_e INIT_ST = (SKIP == 0) ? ST_ACCUM : ST_WARMUP;

    if ((ACC_W < IN_W + $clog2(WIN_LEN)) || (WIN_LEN < 2)) begin : g_bad_cfg
        $error("ne_window_accum: need WIN_LEN >= 2 and ACC_W >= IN_W + clog2(WIN_LEN)");
    end

    ne_state_e          state_q, state_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               above_q, above_d;

    logic [ACC_W-1:0]   din_ext;
    logic [ACC_W-1:0]   sum;
    logic               skip_last;
    logic               cnt_last;

    assign din_ext   = {{(ACC_W-IN_W){din[IN_W-1]}}, din};
    assign sum       = acc_q + din_ext;
    assign skip_last = (int'(skip_q) == SKIP - 1);
    assign cnt_last  = (cnt_q == CNT_W'(WIN_LEN - 1));

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        above_d = above_q;
        valid_d = 1'b0;

        if (clear) begin
            state_d = INIT_ST;
            skip_d  = '0;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (din_valid) begin
            unique case (state_q)
                ST_WARMUP: begin
                    if (skip_last) begin
                        state_d = ST_ACCUM;
                        skip_d  = '0;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        skip_d = skip_q + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (cnt_last) begin
                        dout_d  = sum;
                        above_d = $signed(sum) > $signed(thresh);
                        valid_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = INIT_ST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT_ST;
            skip_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            above_q <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            above_q <= above_d;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = valid_q;
    assign above_thresh = above_q;

endmodule

// File: tb/tb_ne_window_accum.sv
// Directed bench for ne_window_accum: one instance with warm-up
// (WIN_LEN=4, SKIP=2) and one without (WIN_LEN=4, SKIP=0).
module tb_ne_window_accum;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [31:0]        din = '0;
    logic               din_valid = 1'b0;
    logic               clear = 1'b0;
    logic signed [47:0] thresh = '0;

    logic signed [47:0] dout0, dout1;
    logic               dv0, dv1, ab0, ab1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ne_window_accum #(.IN_W(32), .WIN_LEN(4), .SKIP(2), .ACC_W(48)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .clear(clear), .thresh(thresh), .dout(dout0),
        .dout_valid(dv0), .above_thresh(ab0)
    );

    ne_window_accum #(.IN_W(32), .WIN_LEN(4), .SKIP(0), .ACC_W(48)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .clear(clear), .thresh(thresh), .dout(dout1),
        .dout_valid(dv1), .above_thresh(ab1)
    );

    // Drive one cycle of input, then sample just after the capturing edge.
    task automatic cyc(input logic v, input int d, input logic c = 1'b0);
        din_valid = v;
        din       = d;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_dout", dout0, 0);
        chk("rst_dv", dv0, 0);
        chk("rst_ab", ab0, 0);

        // Basic window: 99,99 skipped, then 1..4
        thresh = 20;
        cyc(1, 99); cyc(1, 99); cyc(1, 1); cyc(1, 2); cyc(1, 3);
        chk("basic_nopulse", dv0, 0);
        cyc(1, 4);
        chk("basic_dv", dv0, 1);
        chk("basic_dout", dout0, 10);
        chk("basic_ab", ab0, 0);
        cyc(0, 0);
        chk("basic_dv_drop", dv0, 0);
        chk("basic_hold", dout0, 10);

        // Gapped input then back-to-back window
        cyc(1, 5); cyc(0, 0); cyc(1, -1); cyc(0, 0); cyc(1, 7); cyc(0, 0);
        chk("gap_nopulse", dv0, 0);
        cyc(1, 30);
        chk("gap_dv", dv0, 1);
        chk("gap_dout", dout0, 41);
        chk("gap_ab", ab0, 1);
        cyc(1, 1);
        chk("b2b_single", dv0, 0);
        chk("b2b_hold", dout0, 41);
        cyc(1, 1); cyc(1, 1); cyc(1, 1);
        chk("b2b_dv", dv0, 1);
        chk("b2b_dout", dout0, 4);
        chk("b2b_ab", ab0, 0);

        // Width extremes on the SKIP=0 instance
        do_reset();
        thresh = 0;
        cyc(1, 1); cyc(0, 0);
        chk("skip0_nopulse", dv1, 0);
        do_reset();
        repeat (4) cyc(1, 32'h8000_0000);
        chk("min_dv", dv1, 1);
        chk("min_dout", dout1, -64'sd8589934592);
        chk("min_ab", ab1, 0);
        repeat (4) cyc(1, 32'h7fff_ffff);
        chk("max_dv", dv1, 1);
        chk("max_dout", dout1, 64'sd8589934588);
        chk("max_ab", ab1, 1);

        // Clear mid-window
        do_reset();
        thresh = 20;
        cyc(1, 99); cyc(1, 99); cyc(1, 1); cyc(1, 2); cyc(1, 3); cyc(1, 4);
        chk("clr_pre", dout0, 10);
        cyc(1, 5); cyc(1, 5);
        cyc(1, 50, 1'b1);
        chk("clr_dv", dv0, 0);
        chk("clr_hold", dout0, 10);
        cyc(1, 99); cyc(1, 99); cyc(1, 1); cyc(1, 1); cyc(1, 1);
        chk("clr_nopulse", dv0, 0);
        chk("clr_hold2", dout0, 10);
        cyc(1, 1);
        chk("clr_dv_after", dv0, 1);
        chk("clr_dout", dout0, 4);

        // Clear on the completing sample loses the window
        cyc(1, 2); cyc(1, 2); cyc(1, 2);
        cyc(1, 2, 1'b1);
        chk("clr_last_dv", dv0, 0);
        chk("clr_last_hold", dout0, 4);
        cyc(0, 0);
        chk("clr_last_dv2", dv0, 0);

        // Reset mid-window
        cyc(1, 99); cyc(1, 99); cyc(1, 1); cyc(1, 1); cyc(1, 1);
        do_reset();
        chk("rmid_dout", dout0, 0);
        chk("rmid_dv", dv0, 0);
        chk("rmid_ab", ab0, 0);
        cyc(1, 1); cyc(1, 1); cyc(1, 1); cyc(1, 1);
        chk("rmid_warm", dv0, 0);
        cyc(1, 1);
        chk("rmid_warm2", dv0, 0);
        cyc(1, 1);
        chk("rmid_dv", dv0, 1);
        chk("rmid_dout2", dout0, 4);

        // Threshold boundaries
        thresh = 10;
        cyc(1, 1); cyc(1, 2); cyc(1, 3); cyc(1, 4);
        chk("th_eq_dout", dout0, 10);
        chk("th_eq_ab", ab0, 0);
        thresh = 9;
        cyc(1, 1); cyc(1, 2); cyc(1, 3); cyc(1, 4);
        chk("th_9_ab", ab0, 1);
        thresh = -5;
        repeat (4) cyc(1, -1);
        chk("th_neg_dout", dout0, -4);
        chk("th_neg_ab", ab0, 1);
        thresh = 100;
        cyc(0, 0);
        chk("th_no_retro", ab0, 1);
        repeat (4) cyc(1, -1);
        chk("th_new_ab", ab0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
